multi_channel_analog_seq: RTL and testbench
===========================================

Name: multi_channel_analog_seq

Overview:
Parametrised successor to the single-channel analog top. It controls NUM_CH analog channels through one shared DAC offset bus and per-channel ADC enables. A scan FSM visits each enabled channel round-robin: it programs the channel's DAC offset, waits a settle time, runs a conversion and captures the sample. Each result leaves on a valid/ready stream tagged with its channel number, so the digital back-end can read all channels from one port.

Parameters:
NUM_CH, 4, number of analog channels (2..16)
DAC_W, 8, DAC offset code width
ADC_W, 8, ADC sample width
SETTLE_CYCLES, 4, cycles held after a DAC update before conversion (>=1)
CONV_CYCLES, 2, cycles o_AnalogEnable is held high per conversion (>=1)
AVG_LOG2, 2, log2 of conversions averaged per channel (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_Start  in  1  single-cycle pulse; starts a scan when idle
i_Continuous  in  1  1 = rescan forever while set; 0 = stop after one scan
i_ChannelEnable  in  NUM_CH  per-channel scan mask
i_DacOffset  in  NUM_CH*DAC_W  per-channel offsets, channel k at bits [k*DAC_W +: DAC_W]
i_AdcSample  in  NUM_CH*ADC_W  per-channel ADC outputs, same packing
o_DacCode  out  DAC_W  offset driven to the shared DAC
o_AnalogEnable  out  NUM_CH  one-hot ADC enable
o_Sample  out  ADC_W  result data
o_SampleChannel  out  $clog2(NUM_CH)  channel that produced o_Sample
o_SampleValid  out  1  result valid
i_SampleReady  in  1  consumer accepts the result
o_Busy  out  1  FSM not in IDLE
o_Overrun  out  1  sticky: a result was dropped
i_ClearOverrun  in  1  clears o_Overrun

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Channel pointer = 0. Latched mask = 0.
- States: IDLE, SELECT, SETTLE, CONVERT, CAPTURE.
- IDLE:
  - On i_Start=1, latch i_ChannelEnable into the scan mask.
  - If the latched mask is all-zero, stay in IDLE. Otherwise go to SELECT.
  - i_Start is ignored outside IDLE.
- SELECT (1 cycle):
  - Pick the lowest enabled channel >= pointer, wrapping modulo NUM_CH.
  - Register o_DacCode <= that channel's offset; record the channel number.
- SETTLE (SETTLE_CYCLES cycles): o_DacCode held.
- CONVERT (CONV_CYCLES cycles): o_AnalogEnable[ch]=1. All other enable bits are always 0.
- CAPTURE (1 cycle):
  - Latch i_AdcSample[ch] into the result path.
  - Set pointer = ch+1, wrapping to 0 after NUM_CH-1.
- After CAPTURE:
  - If ch was the highest enabled channel of the mask and i_Continuous=0, go to IDLE.
  - If ch was the highest enabled channel and i_Continuous=1, re-latch the mask from i_ChannelEnable, then go to SELECT.
  - Otherwise go to SELECT.
- Mask changes on i_ChannelEnable mid-scan have no effect until the next re-latch.
- Latency: with defaults, o_SampleValid rises 8 cycles after the edge that samples i_Start (SELECT 1 + SETTLE 4 + CONVERT 2 + CAPTURE 1). Per-channel period = SETTLE_CYCLES+CONV_CYCLES+2.
- Output stream:
  - o_SampleValid/o_Sample/o_SampleChannel are set on the edge ending CAPTURE.
  - They hold stable until a cycle with valid&ready. Valid drops after that cycle unless a new capture lands on the same edge, in which case the new result is loaded and valid stays 1.
  - If valid=1 and ready=0 at capture, the new result is dropped, the old one is kept and o_Overrun is set.
  - i_ClearOverrun has priority below a same-cycle set.
- o_Busy = (state != IDLE).
- reset_n asserted mid-scan aborts immediately to the reset values; any pending result is lost.

Optional Feature:
CHANNEL_SEQ_AVERAGE_EN
- Defined:
  - Each channel visit runs 2^AVG_LOG2 back-to-back CONVERT+CAPTURE pairs. SETTLE runs only once, before the first conversion.
  - Captures are summed in an accumulator of width ADC_W+AVG_LOG2.
  - The result is the sum >> AVG_LOG2 (truncated). It is emitted once, after the last capture.
  - o_AnalogEnable drops for exactly 1 cycle between conversions.
- Undefined: one conversion per visit, and AVG_LOG2 is ignored.

Test Plan:
1. Mask=4'b1111, offsets 0x10/0x20/0x30/0x40, ADC slices 0xA0..0xA3, i_Start pulse, ready=1 -> four results, channels 0..3, data 0xA0..0xA3, 8 cycles apart. o_DacCode steps 0x10..0x40. Busy drops after the 4th result.
2. Mask=4'b1010, continuous=1 -> channel order 1,3,1,3,…; o_AnalogEnable never shows bit 0 or 2. Clearing i_Continuous mid-scan -> stops after channel 3.
3. Mask=0 with i_Start -> o_Busy stays 0 and no valid output.
4. ready=0 for 2 channel periods -> first result held stable, second dropped, o_Overrun=1. i_ClearOverrun -> 0.
5. reset_n low during CONVERT -> all outputs 0 asynchronously. Next i_Start restarts at channel 0.
6. (CHANNEL_SEQ_AVERAGE_EN, AVG_LOG2=2) ADC returns 0x10,0x11,0x12,0x13 on successive conversions -> one result 0x11 per channel.

Source files
------------

// File: rtl/multi_channel_analog_seq_if.sv
// Result stream of the multi-channel analog sequencer: one sample per
// channel visit, tagged with the channel that produced it, valid/ready
// handshake. The sequencer drives through the master modport; the digital
// back-end consumes through the slave modport.
interface multi_channel_analog_seq_if #(
  parameter int ADC_W = 8,
  parameter int CH_W  = 2
);
  logic [ADC_W-1:0] o_Sample;
  logic [CH_W-1:0]  o_SampleChannel;
  logic             o_SampleValid;
  logic             i_SampleReady;

  modport master (
    output o_Sample,
    output o_SampleChannel,
    output o_SampleValid,
    input  i_SampleReady
  );

  modport slave (
    input  o_Sample,
    input  o_SampleChannel,
    input  o_SampleValid,
    output i_SampleReady
  );
endinterface

// File: rtl/multi_channel_analog_seq.sv
// Multi-channel analog sequencer. Visits every enabled channel round-robin:
// drives its DAC offset, waits for the analog path to settle, pulses that
// channel's ADC enable and captures the sample onto a tagged result stream.
// Optional feature macro CHANNEL_SEQ_AVERAGE_EN: each visit averages
// 2^AVG_LOG2 back-to-back conversions instead of taking a single one.
module multi_channel_analog_seq #(
  parameter int NUM_CH        = 4,
  parameter int DAC_W         = 8,
  parameter int ADC_W         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CONV_CYCLES   = 2,
  parameter int AVG_LOG2      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_Start,
  input  logic                    i_Continuous,
  input  logic [NUM_CH-1:0]       i_ChannelEnable,
  input  logic [NUM_CH*DAC_W-1:0] i_DacOffset,
  input  logic [NUM_CH*ADC_W-1:0] i_AdcSample,
  output logic [DAC_W-1:0]        o_DacCode,
  output logic [NUM_CH-1:0]       o_AnalogEnable,
  output logic                    o_Busy,
  output logic                    o_Overrun,
  input  logic                    i_ClearOverrun,
  multi_channel_analog_seq_if.master res
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2((SETTLE_CYCLES > CONV_CYCLES ? SETTLE_CYCLES : CONV_CYCLES) + 1);
`ifdef CHANNEL_SEQ_AVERAGE_EN
  localparam int AVG_SHIFT = AVG_LOG2;
`else
  // Single conversion per visit: the averaging depth has no effect.
  localparam int AVG_SHIFT = 0 * AVG_LOG2;
`endif
  localparam int AVG_N = 1 << AVG_SHIFT;
  localparam int ACC_W = ADC_W + AVG_SHIFT;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_CONVERT, S_CAPTURE} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DAC_W-1:0]    dac_q, dac_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AVG_SHIFT:0]  avg_q, avg_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADC_W-1:0]    sample_q, sample_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic [CH_W-1:0]     sel_ge, sel_any, sel_ch, hi_ch;
  logic                found_ge;
  logic [ADC_W-1:0]    adc_slice;
  logic [ACC_W-1:0]    sum;
  logic                last_conv;
  logic                capture_done;

  // Channel search: lowest enabled channel at/after the pointer (with wrap)
  // and the highest enabled channel, which marks the end of a scan.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_ge   = '0;
    sel_any  = '0;
    hi_ch    = '0;
    found_ge = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_any = CH_W'(i);
        if (i >= int'(ptr_q)) begin
          sel_ge   = CH_W'(i);
          found_ge = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask_q[i]) hi_ch = CH_W'(i);
    end
  end

  assign sel_ch       = found_ge ? sel_ge : sel_any;
  assign adc_slice    = i_AdcSample[int'(ch_q)*ADC_W +: ADC_W];
  assign sum          = acc_q + ACC_W'(adc_slice);
  assign last_conv    = (avg_q == (AVG_SHIFT+1)'(AVG_N - 1));
  assign capture_done = (state_q == S_CAPTURE) && last_conv;

  // State register.
  // NOTE: reset is asynchronous; every flop uses non-blocking assignment so
  // all state updates on a clock edge see the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_Start && (|i_ChannelEnable)) state_d = S_SELECT;
      S_SELECT:  state_d = S_SETTLE;
      S_SETTLE:  if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = S_CONVERT;
      S_CONVERT: if (cnt_q == CNT_W'(CONV_CYCLES - 1)) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (!last_conv)                               state_d = S_CONVERT;
        else if (ch_q != hi_ch)                       state_d = S_SELECT;
        // A re-latched empty mask has nothing to visit, so the scan ends.
        else if (i_Continuous && (|i_ChannelEnable))  state_d = S_SELECT;
        else                                          state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: mask, pointer, DAC code, timers, accumulator and
  // the result stream with overrun detection.
  always_comb begin
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    dac_d     = dac_q;
    avg_d     = avg_q;
    acc_d     = acc_q;
    cnt_d     = '0;
    sample_d  = sample_q;
    chan_d    = chan_q;
    valid_d   = valid_q & ~res.i_SampleReady;
    overrun_d = overrun_q & ~i_ClearOverrun;

    if ((state_q == S_SETTLE || state_q == S_CONVERT) && state_d == state_q)
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: if (i_Start) mask_d = i_ChannelEnable;
      S_SELECT: begin
        ch_d  = sel_ch;
        dac_d = i_DacOffset[int'(sel_ch)*DAC_W +: DAC_W];
        avg_d = '0;
        acc_d = '0;
      end
      S_CAPTURE: begin
        avg_d = avg_q + 1'b1;
        acc_d = sum;
        if (last_conv) begin
          ptr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          if (ch_q == hi_ch && i_Continuous) mask_d = i_ChannelEnable;
        end
      end
      default: ;
    endcase

    // A new result replaces the old one only if the slot is free or being
    // drained this cycle; otherwise it is dropped and flagged.
    if (capture_done) begin
      if (!valid_q || res.i_SampleReady) begin
        sample_d = ADC_W'(sum >> AVG_SHIFT);
        chan_d   = ch_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      ptr_q     <= '0;
      ch_q      <= '0;
      dac_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      chan_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      ch_q      <= ch_d;
      dac_q     <= dac_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      chan_q    <= chan_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decoded from state; only the visited channel is ever enabled.
  always_comb begin
    o_Busy         = (state_q != S_IDLE);
    o_AnalogEnable = '0;
    if (state_q == S_CONVERT) o_AnalogEnable = NUM_CH'(1) << ch_q;
  end

  assign o_DacCode           = dac_q;
  assign o_Overrun           = overrun_q;
  assign res.o_Sample        = sample_q;
  assign res.o_SampleChannel = chan_q;
  assign res.o_SampleValid   = valid_q;

endmodule

// File: tb/tb_multi_channel_analog_seq.sv
// Directed bench for multi_channel_analog_seq with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_multi_channel_analog_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_Start;
  logic        i_Continuous;
  logic [3:0]  i_ChannelEnable;
  logic [31:0] i_DacOffset;
  logic [31:0] i_AdcSample;
  logic [7:0]  o_DacCode;
  logic [3:0]  o_AnalogEnable;
  logic        o_Busy;
  logic        o_Overrun;
  logic        i_ClearOverrun;
  logic [3:0]  seen;

  int n_checks = 0;
  int n_fail   = 0;

  multi_channel_analog_seq_if #(.ADC_W(8), .CH_W(2)) res_if ();

  multi_channel_analog_seq dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_Start         (i_Start),
    .i_Continuous    (i_Continuous),
    .i_ChannelEnable (i_ChannelEnable),
    .i_DacOffset     (i_DacOffset),
    .i_AdcSample     (i_AdcSample),
    .o_DacCode       (o_DacCode),
    .o_AnalogEnable  (o_AnalogEnable),
    .o_Busy          (o_Busy),
    .o_Overrun       (o_Overrun),
    .i_ClearOverrun  (i_ClearOverrun),
    .res             (res_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n              = 1'b0;
    i_Start              = 1'b0;
    i_Continuous         = 1'b0;
    i_ChannelEnable      = 4'h0;
    i_ClearOverrun       = 1'b0;
    i_DacOffset          = {8'h40, 8'h30, 8'h20, 8'h10};
    i_AdcSample          = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    res_if.i_SampleReady = 1'b1;

    // Reset values
    #3;
    check("rst_busy",  o_Busy, 0);
    check("rst_en",    o_AnalogEnable, 0);
    check("rst_dac",   o_DacCode, 0);
    check("rst_valid", res_if.o_SampleValid, 0);
    check("rst_ovr",   o_Overrun, 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);

`ifdef CHANNEL_SEQ_AVERAGE_EN
    // Averaging: four conversions 0x10..0x13 on channel 0 -> one result 0x11
    i_ChannelEnable = 4'b0001;
    i_AdcSample     = {8'hA3, 8'hA2, 8'hA1, 8'h10};
    i_Start = 1'b1;
    tick(1);
    i_Start = 1'b0;
    tick(7);
    check("avg_gap_en", o_AnalogEnable, 0);
    tick(1);
    check("avg_conv2_en", o_AnalogEnable, 4'b0001);
    i_AdcSample[7:0] = 8'h11;
    tick(3);
    i_AdcSample[7:0] = 8'h12;
    tick(3);
    i_AdcSample[7:0] = 8'h13;
    tick(2);
    check("avg_not_yet", res_if.o_SampleValid, 0);
    tick(1);
    check("avg_valid", res_if.o_SampleValid, 1);
    check("avg_data",  res_if.o_Sample, 8'h11);
    check("avg_chan",  res_if.o_SampleChannel, 0);
    check("avg_idle",  o_Busy, 0);
`else
    // Test 1: full mask single scan, results 8 cycles apart
    i_ChannelEnable = 4'hF;
    i_Start = 1'b1;
    tick(1);
    i_Start = 1'b0;
    check("t1_busy", o_Busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check($sformatf("t1_dac%0d", k),   o_DacCode, 16 * (k + 1));
      check($sformatf("t1_vlow%0d", k),  res_if.o_SampleValid, 0);
      tick(4);
      check($sformatf("t1_en%0d", k),    o_AnalogEnable, 1 << k);
      tick(2);
      check($sformatf("t1_early%0d", k), res_if.o_SampleValid, 0);
      tick(1);
      check($sformatf("t1_valid%0d", k), res_if.o_SampleValid, 1);
      check($sformatf("t1_data%0d", k),  res_if.o_Sample, 8'hA0 + k);
      check($sformatf("t1_chan%0d", k),  res_if.o_SampleChannel, k);
    end
    check("t1_busy_end", o_Busy, 0);

    // Test 2: sparse mask, continuous, mid-scan mask change ignored
    tick(2);
    i_ChannelEnable = 4'b1010;
    i_Continuous    = 1'b1;
    i_Start = 1'b1;
    tick(1);
    i_Start = 1'b0;
    i_ChannelEnable = 4'b0101;
    seen = 4'h0;
    for (int c = 0; c < 8; c++) begin tick(1); seen |= o_AnalogEnable; end
    check("t2_chan_a", res_if.o_SampleChannel, 1);
    check("t2_data_a", res_if.o_Sample, 8'hA1);
    i_ChannelEnable = 4'b1010;
    for (int c = 0; c < 8; c++) begin tick(1); seen |= o_AnalogEnable; end
    check("t2_chan_b", res_if.o_SampleChannel, 3);
    for (int c = 0; c < 8; c++) begin tick(1); seen |= o_AnalogEnable; end
    check("t2_chan_c", res_if.o_SampleChannel, 1);
    i_Continuous = 1'b0;
    for (int c = 0; c < 8; c++) begin tick(1); seen |= o_AnalogEnable; end
    check("t2_chan_d",  res_if.o_SampleChannel, 3);
    check("t2_valid_d", res_if.o_SampleValid, 1);
    check("t2_stop",    o_Busy, 0);
    tick(10);
    check("t2_quiet_v", res_if.o_SampleValid, 0);
    check("t2_quiet_b", o_Busy, 0);
    check("t2_en_seen", seen, 4'b1010);

    // Test 3: empty mask never starts
    i_ChannelEnable = 4'h0;
    i_Start = 1'b1;
    tick(1);
    i_Start = 1'b0;
    check("t3_busy", o_Busy, 0);
    tick(10);
    check("t3_busy2", o_Busy, 0);
    check("t3_valid", res_if.o_SampleValid, 0);

    // Test 4: back-pressure holds first result, drops second, sets overrun
    res_if.i_SampleReady = 1'b0;
    i_ChannelEnable = 4'b0011;
    i_Start = 1'b1;
    tick(1);
    i_Start = 1'b0;
    tick(8);
    check("t4_valid1", res_if.o_SampleValid, 1);
    check("t4_data1",  res_if.o_Sample, 8'hA0);
    check("t4_ovr0",   o_Overrun, 0);
    tick(4);
    check("t4_hold_d", res_if.o_Sample, 8'hA0);
    check("t4_hold_v", res_if.o_SampleValid, 1);
    tick(4);
    check("t4_kept_d", res_if.o_Sample, 8'hA0);
    check("t4_kept_c", res_if.o_SampleChannel, 0);
    check("t4_ovr1",   o_Overrun, 1);
    check("t4_idle",   o_Busy, 0);
    res_if.i_SampleReady = 1'b1;
    tick(1);
    check("t4_drain", res_if.o_SampleValid, 0);
    check("t4_sticky", o_Overrun, 1);
    i_ClearOverrun = 1'b1;
    tick(1);
    i_ClearOverrun = 1'b0;
    check("t4_clear", o_Overrun, 0);

    // Test 5: reset during CONVERT, then restart from channel 0
    i_ChannelEnable = 4'hF;
    i_Start = 1'b1;
    tick(1);
    i_Start = 1'b0;
    tick(5);
    check("t5_conv_en",  o_AnalogEnable, 4'b0100);
    check("t5_conv_dac", o_DacCode, 8'h30);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_en",   o_AnalogEnable, 0);
    check("t5_rst_dac",  o_DacCode, 0);
    check("t5_rst_busy", o_Busy, 0);
    check("t5_rst_val",  res_if.o_SampleValid, 0);
    check("t5_rst_smp",  res_if.o_Sample, 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    i_Start = 1'b1;
    tick(1);
    i_Start = 1'b0;
    tick(1);
    check("t5_re_dac", o_DacCode, 8'h10);
    tick(7);
    check("t5_re_val",  res_if.o_SampleValid, 1);
    check("t5_re_chan", res_if.o_SampleChannel, 0);
    check("t5_re_data", res_if.o_Sample, 8'hA0);
    tick(24);
    check("t5_done", o_Busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
